// File: rtl/rx_frame_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : rx_frame_reader                                              |
// | Purpose : Reads one received Ethernet frame from the receiver RX FIFO, |
// |           captures destination/source MAC, filters on EtherType and    |
// |           minimum length, streams the remaining 32-bit words out on a  |
// |           valid/ready interface and pulses rx_release when finished.   |
// | Ports   : clk_100_mhz, rst_n (sync, active-low)                        |
// |           rx_ready/rx_data_count/rx_protocol_type : frame descriptor   |
// |           fifo_data/fifo_empty/fifo_rd_en         : standard-mode FIFO |
// |           rx_release                              : receiver re-arm    |
// |           m_data/m_valid/m_last/m_ready           : payload stream     |
// |           dst_mac/src_mac                         : header fields      |
// |           frames_ok/frames_dropped                : wrapping counters  |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module rx_frame_reader #(
  parameter logic [15:0] ACCEPT_TYPE    = 16'h0800,
  parameter logic        ACCEPT_ANY     = 1'b0,
  parameter logic [15:0] MIN_BYTES      = 16'd60,
  parameter int unsigned RELEASE_CYCLES = 4,
  parameter int unsigned TIMEOUT        = 1024
) (
  input  logic        clk_100_mhz,
  input  logic        rst_n,
  input  logic        rx_ready,
  input  logic [15:0] rx_data_count,
  input  logic [15:0] rx_protocol_type,
  input  logic [31:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        rx_release,
  output logic [31:0] m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [47:0] dst_mac,
  output logic [47:0] src_mac,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_dropped
);

  localparam int unsigned             c_REL_W    = $clog2(RELEASE_CYCLES);
  localparam int unsigned             c_TMO_W    = $clog2(TIMEOUT);
  localparam logic [c_REL_W-1:0]      c_REL_LAST = c_REL_W'(RELEASE_CYCLES - 1);
  localparam logic [c_TMO_W-1:0]      c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HDR      = 3'd1,
    S_PAYLOAD  = 3'd2,
    S_DRAIN    = 3'd3,
    S_RELEASE  = 3'd4,
    S_WAIT_LOW = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, rdy_s_q;
  logic [15:0]          count_q, type_q;
  logic [15:0]          widx_q;       // number of FIFO reads issued this frame
  logic                 rd_pend_q;    // FIFO dout carries the word read last cycle
  logic [c_TMO_W-1:0]   tmo_q;
  logic [c_REL_W-1:0]   rel_cnt_q;
  logic                 rel_q;
  logic                 m_valid_q, m_last_q;
  logic [47:0]          dst_q, src_q;
  logic [15:0]          ok_q, drop_cnt_q;

  logic [15:0]          w_nwords, w_hdr_n;
  logic                 w_drop, w_want_rd, w_starve, w_abort, w_inc_ok, w_inc_drop;

  assign w_nwords = {2'b00, count_q[15:2]};
  // Dropped frames shorter than three words only read what exists.
  assign w_hdr_n  = (w_nwords < 16'd3) ? w_nwords : 16'd3;
  assign w_drop   = (count_q < MIN_BYTES) ||
                    (!ACCEPT_ANY && (type_q != ACCEPT_TYPE)) ||
                    (w_nwords < 16'd4);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_100_mhz) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    w_want_rd  = 1'b0;
    w_inc_ok   = 1'b0;
    w_inc_drop = 1'b0;
    w_abort    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rdy_s_q) state_d = S_HDR;
      end
      S_HDR: begin
        w_want_rd = (widx_q < w_hdr_n) && !rd_pend_q;
        // Accepted frames wait for word 2 to land before leaving.
        if ((widx_q == w_hdr_n) && (rd_pend_q || w_drop))
          state_d = w_drop ? S_DRAIN : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        w_want_rd = (widx_q < w_nwords) && (!m_valid_q || m_ready) && !rd_pend_q;
        if (m_valid_q && m_ready && m_last_q) begin
          w_inc_ok = 1'b1;
          state_d  = S_RELEASE;
        end
      end
      S_DRAIN: begin
        if (widx_q >= w_nwords) begin
          w_inc_drop = 1'b1;
          state_d    = S_RELEASE;
        end else begin
          w_want_rd = !rd_pend_q;
          if (!rd_pend_q && !fifo_empty && (widx_q + 16'd1 == w_nwords)) begin
            w_inc_drop = 1'b1;
            state_d    = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        if (rel_cnt_q == c_REL_LAST) state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!rdy_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Starvation: a read is wanted but the FIFO has nothing to give.
    w_starve = w_want_rd && fifo_empty;
    if (w_starve && (tmo_q == c_TMO_LAST)) begin
      w_abort    = 1'b1;
      w_inc_drop = 1'b1;
      state_d    = S_RELEASE;
    end
  end

  assign fifo_rd_en = w_want_rd && !fifo_empty;

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk_100_mhz) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      rdy_s_q    <= 1'b0;
      count_q    <= 16'h0;
      type_q     <= 16'h0;
      widx_q     <= 16'h0;
      rd_pend_q  <= 1'b0;
      tmo_q      <= '0;
      rel_cnt_q  <= '0;
      rel_q      <= 1'b0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      dst_q      <= 48'h0;
      src_q      <= 48'h0;
      ok_q       <= 16'h0;
      drop_cnt_q <= 16'h0;
    end else begin
      sync1_q   <= rx_ready;
      rdy_s_q   <= sync1_q;
      rd_pend_q <= fifo_rd_en;
      rel_q     <= (state_d == S_RELEASE);

      if ((state_q == S_IDLE) && rdy_s_q) begin
        count_q <= rx_data_count;
        type_q  <= rx_protocol_type;
        widx_q  <= 16'h0;
      end else if (fifo_rd_en) begin
        widx_q  <= widx_q + 16'd1;
      end

      if (w_starve && !w_abort) tmo_q <= tmo_q + 1'b1;
      else                      tmo_q <= '0;

      if (state_q == S_RELEASE) rel_cnt_q <= rel_cnt_q + 1'b1;
      else                      rel_cnt_q <= '0;

      // widx_q already counts the read whose data is now on fifo_data.
      if ((state_q == S_HDR) && rd_pend_q && !w_drop) begin
        case (widx_q)
          16'd1: dst_q[47:16] <= fifo_data;
          16'd2: begin
            dst_q[15:0]  <= fifo_data[31:16];
            src_q[47:32] <= fifo_data[15:0];
          end
          16'd3: src_q[31:0] <= fifo_data;
          default: ;
        endcase
      end

      if (w_abort) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end else if ((state_q == S_PAYLOAD) && fifo_rd_en) begin
        m_valid_q <= 1'b1;
        m_last_q  <= (widx_q + 16'd1 == w_nwords);
      end else if (m_valid_q && m_ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end

      if (w_inc_ok)   ok_q       <= ok_q + 16'd1;
      if (w_inc_drop) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  // The FIFO dout holds until the next read, and a payload read is only
  // issued once the presented word is consumed, so dout is the output word.
  assign m_data         = m_valid_q ? fifo_data : 32'h0;
  assign m_valid        = m_valid_q;
  assign m_last         = m_last_q;
  assign rx_release     = rel_q;
  assign dst_mac        = dst_q;
  assign src_mac        = src_q;
  assign frames_ok      = ok_q;
  assign frames_dropped = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_rx_frame_reader                                           |
// | Purpose : Self-checking bench for rx_frame_reader with a FIFO model,   |
// |           randomized frame contents and a byte-level reference model.  |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_rx_frame_reader;

  localparam int c_TIMEOUT = 1024;
  localparam int c_REL     = 4;

  logic        clk = 1'b0;
  logic        rst_n, rx_ready, m_ready;
  logic [15:0] rx_data_count, rx_protocol_type;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd_en, rx_release, m_valid, m_last;
  logic [31:0] m_data;
  logic [47:0] dst_mac, src_mac;
  logic [15:0] frames_ok, frames_dropped;

  always #5 clk = ~clk;

  rx_frame_reader #(
    .ACCEPT_TYPE(16'h0800), .ACCEPT_ANY(1'b0), .MIN_BYTES(16'd60),
    .RELEASE_CYCLES(c_REL), .TIMEOUT(c_TIMEOUT)
  ) dut (
    .clk_100_mhz(clk), .rst_n(rst_n), .rx_ready(rx_ready),
    .rx_data_count(rx_data_count), .rx_protocol_type(rx_protocol_type),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .rx_release(rx_release), .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_ready(m_ready), .dst_mac(dst_mac), .src_mac(src_mac),
    .frames_ok(frames_ok), .frames_dropped(frames_dropped)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------ standard-mode FIFO
  logic [31:0] fq[$];

  always @(posedge clk) begin
    if (!rst_n)                           fifo_data <= 32'h0;
    else if (rx_release)                  fq.delete();
    else if (fifo_rd_en && fq.size() > 0) fifo_data <= fq.pop_front();
  end

  always @(posedge clk) begin
    #2;
    fifo_empty = (fq.size() == 0);
  end

  // ------------------------------------------------------- monitor
  int          cyc = 0;
  int          reads = 0, rel_pulses = 0, rel_width = 0, cur_rel = 0;
  int          last_rd_cyc = 0, rel_rise_cyc = 0;
  logic        prev_rd = 1'b0, prev_stall = 1'b0, prev_last = 1'b0, prev_rstn = 1'b0;
  logic [31:0] prev_data = 32'h0;
  logic [31:0] got_data[$];
  logic        got_last[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && prev_rstn) begin
      if (fifo_rd_en) begin
        reads++;
        last_rd_cyc = cyc;
        chk("rd_protocol{empty,back2back}", {62'b0, fifo_empty, prev_rd}, 64'h0);
      end
      if (prev_stall)
        chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
      if (m_valid && m_ready) begin
        got_data.push_back(m_data);
        got_last.push_back(m_last);
      end
      if (rx_release) begin
        if (cur_rel == 0) rel_rise_cyc = cyc;
        cur_rel++;
      end else if (cur_rel != 0) begin
        rel_width = cur_rel;
        rel_pulses++;
        cur_rel = 0;
      end
    end
    prev_rd    = fifo_rd_en;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    prev_rstn  = rst_n;
  end

  // ------------------------------------------------ reference state
  logic [15:0] exp_ok = 16'h0, exp_drop = 16'h0;
  logic [47:0] exp_dst = 48'h0, exp_src = 48'h0;

  task automatic chk_zero(input string tag);
    chk({tag, " rd_en"},   fifo_rd_en, 0);
    chk({tag, " release"}, rx_release, 0);
    chk({tag, " valid"},   {m_valid, m_last}, 0);
    chk({tag, " data"},    m_data, 0);
    chk({tag, " macs"},    {dst_mac, src_mac} == 96'h0, 1);
    chk({tag, " counters"}, {frames_ok, frames_dropped}, 0);
  endtask

  // Build a frame of cnt random bytes, load the first load_lim words (0 = all)
  // and check everything the reference rules predict for it.
  task automatic run_frame(input logic [15:0] cnt, input logic [15:0] typ, input bit bp,
                           input int load_lim, input bit hold, input string tag);
    logic [7:0]  fb[$];
    logic [31:0] fw[$];
    logic [31:0] w;
    int nw, nload, exp_n, exp_reads, r0, p0;
    bit acc, to, done;
    for (int i = 0; i < int'(cnt); i++) fb.push_back(8'($urandom));
    for (int i = 0; i < (int'(cnt) + 3) / 4; i++) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++)
        if (4 * i + b < int'(cnt)) w[31 - 8 * b -: 8] = fb[4 * i + b];
      fw.push_back(w);
    end
    nw    = int'(cnt) / 4;
    nload = (load_lim > 0 && load_lim < fw.size()) ? load_lim : fw.size();
    acc   = (cnt >= 16'd60) && (typ == 16'h0800) && (nw >= 4);
    to    = (nload < nw);
    for (int i = 0; i < nload; i++) fq.push_back(fw[i]);

    got_data.delete();
    got_last.delete();
    r0 = reads;
    p0 = rel_pulses;
    rx_data_count    = cnt;
    rx_protocol_type = typ;
    m_ready          = 1'b1;
    rx_ready         = 1'b1;
    done             = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk); #1;
      m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      done    = (rel_pulses > p0);
    end
    m_ready = 1'b1;
    chk({tag, " frame_completes"}, done, 1);

    exp_reads = to ? nload : nw;
    exp_n     = acc ? (exp_reads - 3) : 0;
    chk({tag, " word_count"}, got_data.size(), exp_n);
    for (int i = 0; i < exp_n && i < got_data.size(); i++)
      chk({tag, " word{last,data}"}, {got_last[i], got_data[i]},
          {(3 + i == nw - 1), fw[3 + i]});
    chk({tag, " fifo_reads"}, reads - r0, exp_reads);
    chk({tag, " release_width"}, rel_width, c_REL);
    if (to) begin
      // Last read at t, accepted at t+1, starving from t+2: abort decided on
      // the TIMEOUT-th starved cycle, release visible the cycle after.
      chk({tag, " abort_latency"}, rel_rise_cyc - last_rd_cyc, c_TIMEOUT + 2);
      chk({tag, " valid_after_abort"}, {m_valid, m_last}, 0);
    end

    if (acc && !to) exp_ok = exp_ok + 16'd1;
    else            exp_drop = exp_drop + 16'd1;
    if (acc) begin
      for (int i = 0; i < 6; i++)  exp_dst = {exp_dst[39:0], fb[i]};
      for (int i = 6; i < 12; i++) exp_src = {exp_src[39:0], fb[i]};
    end
    chk({tag, " frames_ok"}, frames_ok, exp_ok);
    chk({tag, " frames_dropped"}, frames_dropped, exp_drop);
    chk({tag, " dst_mac"}, dst_mac, exp_dst);
    chk({tag, " src_mac"}, src_mac, exp_src);

    if (hold) begin
      // rx_ready still high: fresh data in the FIFO must not be touched.
      for (int i = 0; i < 4; i++) fq.push_back($urandom);
      r0 = reads;
      repeat (100) @(posedge clk);
      #1;
      chk({tag, " no_reread_while_ready_high"}, reads - r0, 0);
      fq.delete();
    end
    rx_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------- stimulus
  initial begin
    int p0;
    bit seen;
    rst_n            = 1'b0;
    rx_ready         = 1'b0;
    m_ready          = 1'b1;
    rx_data_count    = 16'h0;
    rx_protocol_type = 16'h0;
    repeat (4) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    run_frame(16'd64, 16'h0800, 1'b0, 0, 1'b0, "ipv4_64");
    run_frame(16'd64, 16'h0806, 1'b0, 0, 1'b0, "arp_drop");
    run_frame(16'd42, 16'h0800, 1'b0, 0, 1'b0, "short_42");
    run_frame(16'd67, 16'h0800, 1'b1, 0, 1'b0, "bp_67");
    for (int k = 0; k < 3; k++)
      run_frame(16'($urandom_range(48, 130)),
                ($urandom_range(0, 1) != 0) ? 16'h0800 : 16'h0806,
                1'b1, 0, 1'b0, "random");
    run_frame(16'd80, 16'h0800, 1'b0, 0, 1'b1, "hold_ready");
    run_frame(16'd64, 16'h0800, 1'b0, 6, 1'b0, "timeout");

    // Reset in the middle of a payload stream.
    for (int i = 0; i < 16; i++) fq.push_back($urandom);
    rx_data_count    = 16'd64;
    rx_protocol_type = 16'h0800;
    m_ready          = 1'b1;
    got_data.delete();
    got_last.delete();
    p0       = rel_pulses;
    rx_ready = 1'b1;
    seen     = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk); #1;
      seen = (got_data.size() >= 3);
    end
    chk("midrst reached_payload", seen, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("midrst");
    rx_ready = 1'b0;
    fq.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("midrst no_release", rel_pulses - p0, 0);
    rst_n    = 1'b1;
    exp_ok   = 16'h0;
    exp_drop = 16'h0;
    exp_dst  = 48'h0;
    exp_src  = 48'h0;
    repeat (3) @(posedge clk);
    #1;
    run_frame(16'd96, 16'h0800, 1'b1, 0, 1'b0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_frame_reader.md
# rx_frame_reader

Consumes one received Ethernet frame at a time from `receiver_wrapper`'s RX FIFO on the 100 MHz side. It captures destination and source MAC, filters on EtherType and minimum length, and forwards the remaining 32-bit words on a valid/ready stream. When the frame is finished, it pulses `rx_release` so the 50 MHz receiver path is reset and re-armed for the next frame.

## Interface
Parameters:
- `ACCEPT_TYPE`, 16'h0800, EtherType forwarded when `ACCEPT_ANY`=0
- `ACCEPT_ANY`, 1'b0, 1 = forward every EtherType
- `MIN_BYTES`, 16'd60, frames with `rx_data_count` below this are dropped
- `RELEASE_CYCLES`, 4, width of the `rx_release` pulse in clk cycles (≥4)
- `TIMEOUT`, 1024, consecutive empty cycles mid-frame before abort

Ports:
- `clk_100_mhz` in 1: sole clock
- `rst_n` in 1: synchronous, active-low reset
- `rx_ready` in 1: frame-complete flag from the 50 MHz domain (asynchronous)
- `rx_data_count` in 16: byte count of the frame, stable while `rx_ready`=1
- `rx_protocol_type` in 16: EtherType, stable while `rx_ready`=1
- `fifo_data` in 32: FIFO dout; first byte received is in [31:24]
- `fifo_empty` in 1: FIFO empty flag
- `fifo_rd_en` out 1: FIFO read strobe
- `rx_release` out 1: active-high reset request to the receiver path
- `m_data` out 32: payload word
- `m_valid` out 1: `m_data` valid
- `m_last` out 1: last word of the frame, qualified by `m_valid`
- `m_ready` in 1: sink accepts word
- `dst_mac` out 48, `src_mac` out 48: header fields of the current or last accepted frame
- `frames_ok` out 16, `frames_dropped` out 16: wrapping event counters

## Operation
- `rx_ready` passes through a 2-flop synchronizer. `rdy_s` is the synchronized value.
- `rx_data_count` and `rx_protocol_type` are registered in the IDLE cycle where `rdy_s` is first seen high.
- `nwords = rx_data_count >> 2` (floor). Trailing 0–3 bytes stay in the FIFO and are cleared by `rx_release`.
- Drop condition, decided at capture: `rx_data_count < MIN_BYTES`, or (`!ACCEPT_ANY` and `rx_protocol_type != ACCEPT_TYPE`). Also dropped if `nwords < 4`.
- FIFO is standard mode: `fifo_data` is valid the cycle after `fifo_rd_en`.
  - At most one read is outstanding.
  - `fifo_rd_en` is asserted only when `!fifo_empty`, and never in two consecutive cycles.
- States:
  - IDLE: wait for `rdy_s`=1. Capture count/type, clear the word counter, then go to HDR.
  - HDR: read words 0, 1, 2. Word0 → `dst_mac[47:16]`. Word1[31:16] → `dst_mac[15:0]`, word1[15:0] → `src_mac[47:32]`. Word2 → `src_mac[31:0]`. MAC registers update only on non-dropped frames. Then go to PAYLOAD, or DRAIN if dropped.
  - PAYLOAD: words 3..`nwords`-1 go to the output register, one read per accepted word. A new read is issued only when `m_valid`=0, or `m_valid`&&`m_ready` in that cycle. `m_last`=1 on word `nwords`-1. After that handshake, increment `frames_ok` and go to RELEASE.
  - DRAIN: read and discard remaining words up to `nwords`. Increment `frames_dropped`, then go to RELEASE.
  - RELEASE: hold `rx_release`=1 for `RELEASE_CYCLES` cycles, then go to WAIT_LOW.
  - WAIT_LOW: wait for `rdy_s`=0, then go to IDLE. This prevents the same frame being read twice.
- Timeout: in HDR, PAYLOAD or DRAIN, a counter runs while `fifo_empty`=1 and a read is needed. Reaching `TIMEOUT` aborts the frame:
  - `m_valid` is cleared without `m_last`.
  - `frames_dropped` increments and the FSM goes to RELEASE.
  - If the frame was already counted as ok, no increment.
- Counters wrap from 16'hFFFF to 0.

## Timing
- Reset values: `fifo_rd_en`=0, `rx_release`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `dst_mac`=0, `src_mac`=0, `frames_ok`=0, `frames_dropped`=0. FSM starts in IDLE, synchronizer flops at 0.
- Reset mid-frame: all outputs go to reset values next edge. No `rx_release` is issued. The system reset also resets the receiver path.
- `rx_ready` rise to IDLE exit: 2–3 cycles.
- Word latency: `fifo_rd_en` at cycle t → `m_valid`=1 with that word at t+1.
- Peak rate: one word per 2 cycles.
- `m_data`/`m_last` hold stable while `m_valid`&&!`m_ready`.
- `rx_release` rises the cycle after the last read or accept. It is exactly `RELEASE_CYCLES` wide, which covers ≥2 clk_50_mhz edges.
- Simultaneous `m_ready` accept and pending read: the accept and the new read happen in the same cycle. No bubble beyond the 2-cycle rule.

## Test plan
- IPv4 frame, count=64, type 0x0800, `m_ready`=1:
  - 13 words out; `m_last` on the 13th.
  - `dst_mac`/`src_mac` match bytes 0–11.
  - `frames_ok`=1; `rx_release` high 4 cycles.
- Type 0x0806 with `ACCEPT_ANY`=0: 0 output words, 16 FIFO reads, `frames_dropped`=1, release pulse issued.
- count=42 (<60): dropped; `fifo_rd_en` pulses 10 times; MAC registers unchanged.
- count=67 with random `m_ready` backpressure:
  - 13 payload words in order, none duplicated or lost.
  - `m_data` stable while stalled.
  - 3 trailing bytes are never read.
- `fifo_empty` forced high after word 5: abort after 1024 cycles, `m_valid`=0, `frames_dropped`=1, release pulse issued.
- `rx_ready` held high for 100 cycles after release: no second frame starts until it falls. `rst_n`=0 mid-PAYLOAD: all outputs zero the next cycle.
